core_lsu_ctrl: RTL
==================

// Module: core_lsu_ctrl
// PURPOSE
//  Sequences data-memory accesses for loads/stores issued from the MEM stage over a req/gnt/rvalid bus.
//  Generates word-aligned address, byte enables and lane-shifted store data; stalls the pipeline until the access completes.
//  Captures the raw read word for the write-back stage, which performs byte/half extraction and sign extension.
//  Flags misaligned accesses without issuing them.
// PARAMETERS
//  XLEN  32  data/address width (only 32 supported)
// PORTS
//  clk_i           in   1     core clock
//  rst_ni          in   1     async active-low reset
//  mem_read_i      in   1     MEM-stage instruction is a load
//  mem_write_i     in   1     MEM-stage instruction is a store (exclusive with mem_read_i)
//  d_size_i        in   4     0001 byte, 0011 half, 1111 word (others treated as word)
//  addr_i          in   XLEN  byte address from ALU
//  wdata_i         in   XLEN  store data, right-justified
//  stall_o         out  1     hold pipeline; access in progress
//  misaligned_o    out  1     1-cycle pulse: access rejected, not issued
//  data_req_o      out  1     bus request
//  data_we_o       out  1     1 = write
//  data_be_o       out  4     byte enables
//  data_addr_o     out  XLEN  word-aligned address ({addr[31:2],2'b00})
//  data_wdata_o    out  XLEN  lane-aligned store data
//  data_gnt_i      in   1     bus accepted request
//  data_rvalid_i   in   1     response valid (reads and writes)
//  data_rdata_i    in   XLEN  read word
//  rd_data_o       out  XLEN  captured raw read word, stable until next load completes
//  rd_valid_o      out  1     1-cycle pulse: rd_data_o updated
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (rd_data_o = 0).
//  FSM states: IDLE, REQ, WAIT, DONE.
//   IDLE: access = mem_read_i|mem_write_i.
//    Aligned access -> register addr/be/wdata/we, go REQ; stall_o=1 combinationally in this cycle.
//    Misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> stay IDLE; misaligned_o=1 that cycle; stall_o=0.
//   REQ: data_req_o=1. addr/be/wdata/we held stable until data_gnt_i. On gnt go WAIT. stall_o=1.
//   WAIT: data_req_o=0, stall_o=1. On data_rvalid_i go DONE; for reads, latch data_rdata_i into rd_data_o.
//   DONE: stall_o=0; rd_valid_o=1 for loads only; unconditionally return to IDLE.
//    Pipeline advances on this edge; the next access is seen in IDLE on the following cycle.
//  Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
//  Store data: wdata_i << (8*addr[1:0]); unused lanes don't-care (driven from the shift).
//  Latency: minimum 4 cycles per access (IDLE detect, REQ w/ same-cycle gnt, WAIT w/ rvalid, DONE).
//  Bus contract: rvalid arrives >=1 cycle after gnt; rvalid outside WAIT is ignored; gnt outside REQ is ignored.
//  Async reset mid-access: immediate return to IDLE, req dropped; a late rvalid after reset is ignored.
//  mem_read_i and mem_write_i both high: treated as store (protocol error, not flagged).
// TESTING
//  1. Word load addr=0x100, gnt same cycle, rvalid next, rdata=0xDEADBEEF
//     -> req 1 cycle, be=1111, addr=0x100, we=0; rd_data_o=0xDEADBEEF;
//        rd_valid_o pulse in DONE; stall high exactly 3 cycles.
//  2. Byte store addr=0x203, wdata=0x000000A5, gnt after 3 wait cycles
//     -> req held 4 cycles, addr/be/wdata stable; addr=0x200, be=1000, wdata[31:24]=0xA5; no rd_valid_o.
//  3. Half load addr=0x102 -> be=1100, addr=0x100.
//     Half load addr=0x101 -> misaligned_o pulse, no req, stall_o=0.
//  4. rst_ni low during WAIT, then rvalid=1 after release
//     -> outputs 0, state IDLE, rvalid ignored, rd_valid_o stays 0.
//  5. Back-to-back loads 0x10, 0x14 -> two clean req/rvalid transactions,
//     one IDLE cycle between DONE and next REQ, rd_data_o updates each.
//  6. Spurious rvalid/gnt while IDLE -> no state change, rd_data_o unchanged.

Source files
------------

// File: rtl/core_lsu_ctrl.sv
// Load/store bus sequencer for the MEM stage.
// Issues one req/gnt/rvalid access at a time and stalls the pipeline until it completes.
module core_lsu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [3:0]      d_size_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic            misaligned_o,
  output logic            data_req_o,
  output logic            data_we_o,
  output logic [3:0]      data_be_o,
  output logic [XLEN-1:0] data_addr_o,
  output logic [XLEN-1:0] data_wdata_o,
  input  logic            data_gnt_i,
  input  logic            data_rvalid_i,
  input  logic [XLEN-1:0] data_rdata_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic              r_load;
  logic [3:0]        r_be;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;

  logic              w_access;
  logic              w_is_byte;
  logic              w_is_half;
  logic              w_misal;
  logic              w_start;
  logic [3:0]        w_be;
  logic [XLEN-1:0]   w_wdata;

  assign w_access  = mem_read_i | mem_write_i;
  assign w_is_byte = (d_size_i == 4'b0001);
  assign w_is_half = (d_size_i == 4'b0011);

  // Unknown size codes fall through to word handling.
  always_comb begin
    w_be    = 4'b0000;
    w_misal = 1'b0;
    unique case (1'b1)
      w_is_byte: begin
        w_be = 4'b0001 << addr_i[1:0];
      end
      w_is_half: begin
        w_be    = 4'b0011 << addr_i[1:0];
        w_misal = addr_i[0];
      end
      default: begin
        w_be    = 4'b1111;
        w_misal = |addr_i[1:0];
      end
    endcase
  end

  assign w_wdata = wdata_i << {addr_i[1:0], 3'b000};
  assign w_start = (r_state == S_IDLE) & w_access & ~w_misal;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_load  <= 1'b0;
      r_be    <= 4'b0000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_REQ;
            r_we    <= mem_write_i;
            r_load  <= ~mem_write_i;
            r_be    <= w_be;
            r_addr  <= {addr_i[XLEN-1:2], 2'b00};
            r_wdata <= w_wdata;
          end
        end
        S_REQ: begin
          if (data_gnt_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            r_state <= S_DONE;
            if (r_load) r_rdata <= data_rdata_i;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_req_o   = (r_state == S_REQ);
  assign data_we_o    = r_we;
  assign data_be_o    = r_be;
  assign data_addr_o  = r_addr;
  assign data_wdata_o = r_wdata;
  assign rd_data_o    = r_rdata;
  assign rd_valid_o   = (r_state == S_DONE) & r_load;
  assign misaligned_o = (r_state == S_IDLE) & w_access & w_misal;
  assign stall_o      = w_start
                      | (r_state == S_REQ)
                      | (r_state == S_WAIT);

endmodule
